// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: FSM state encoding and slave address map shared by the APB master
package apb_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} apb_state_e;

   localparam int NUM_SLV = 4;
   localparam logic [31:0] SLV_BASE [NUM_SLV] = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000, 32'h8C00_0000};
   localparam logic [31:0] SLV_LIMIT [NUM_SLV] = '{32'h83FF_FFFF, 32'h87FF_FFFF, 32'h8BFF_FFFF, 32'h8FFF_FFFF};

   function automatic logic [NUM_SLV-1:0] decode_psel(input logic [31:0] addr);
      logic [NUM_SLV-1:0] psel;
      for (int i = 0; i < NUM_SLV; i++) psel[i] = (addr >= SLV_BASE[i]) && (addr <= SLV_LIMIT[i]);
      return psel;
   endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin grant to the first valid requester at or after the pointer
module apb_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic                       enable,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

   localparam int IW = $clog2(NUM_REQ);

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_cand;
   logic          w_any;

   // Scan downwards so the candidate closest to the pointer wins last
   always_comb begin
      grant_idx = r_ptr;
      w_cand = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_cand = IW'((int'(r_ptr) + k) % NUM_REQ);
         if (req_valid[w_cand]) grant_idx = w_cand;
      end
   end

   assign w_any = enable && (req_valid != '0);
   assign grant = w_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

   always_ff @(posedge clock) begin
      if (reset) r_ptr <= '0;
      else if (w_any) r_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB bus among NUM_REQ requesters with round-robin arbitration
module apb_master_arbiter
   import apb_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      rsp_err,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [3:0]                Pselx,
   output logic                      Penable,
   output logic                      Pwrite,
   output logic [ADDR_W-1:0]         Paddr,
   output logic [DATA_W-1:0]         Pwdata,
   input  logic [DATA_W-1:0]         Prdata
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   apb_state_e          r_state;
   logic [IW-1:0]       r_idx;
   logic [3:0]          r_psel;
   logic                r_penable;
   logic                r_pwrite;
   logic [ADDR_W-1:0]   r_paddr;
   logic [DATA_W-1:0]   r_pwdata;
   logic [NUM_REQ-1:0]  r_rsp_valid;
   logic                r_rsp_err;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [IW-1:0]       w_gnt_idx;
   logic                w_gnt_write;
   logic [ADDR_W-1:0]   w_gnt_addr;
   logic [DATA_W-1:0]   w_gnt_wdata;
   logic [3:0]          w_dec;

   apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .enable    (!reset && r_state != SETUP),
      .grant     (w_gnt),
      .grant_idx (w_gnt_idx)
   );

   always_comb begin
      w_gnt_write = 1'b0;
      w_gnt_addr = '0;
      w_gnt_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_idx == IW'(i)) begin
            w_gnt_write = req_write[i];
            w_gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_gnt_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_dec = decode_psel(32'(w_gnt_addr));

   // A grant in ACCESS or ERR overlaps the response of the finishing transfer
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx <= '0;
         r_psel <= '0;
         r_penable <= 1'b0;
         r_pwrite <= 1'b0;
         r_paddr <= '0;
         r_pwdata <= '0;
         r_rsp_valid <= '0;
         r_rsp_err <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= (r_state == ACCESS || r_state == ERR) ? ONE << r_idx : '0;
         r_rsp_err <= r_state == ERR;
         r_rsp_rdata <= (r_state == ACCESS && !r_pwrite) ? Prdata : '0;
         r_penable <= r_state == SETUP;
         if (r_state == SETUP) begin
            r_state <= ACCESS;
         end else if (w_gnt != '0) begin
            r_state <= (w_dec != '0) ? SETUP : ERR;
            r_psel <= w_dec;
            r_idx <= w_gnt_idx;
            r_pwrite <= w_gnt_write;
            r_paddr <= w_gnt_addr;
            r_pwdata <= w_gnt_write ? w_gnt_wdata : '0;
         end else begin
            r_state <= IDLE;
            r_psel <= '0;
         end
      end
   end

   assign req_ready = w_gnt;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign Pselx = r_psel;
   assign Penable = r_penable;
   assign Pwrite = r_pwrite;
   assign Paddr = r_paddr;
   assign Pwdata = r_pwdata;

endmodule
